// File: rtl/ucca_config.sv
// ucca_config: bus-programmed UCCA compartment bounds with arm/freeze FSM and violation log
module ucca_config (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    output logic [15:0] per_dout,
    input  logic [15:0] pc,
    input  logic        ucca_viol,
    output logic [15:0] ucc_min,
    output logic [15:0] ucc_max,
    output logic        ucc_armed
);
    localparam logic [15:0] CONF_BASE = 16'h0160;
    localparam logic [13:0] BASE_W    = CONF_BASE[14:1];

    typedef enum logic [1:0] {IDLE = 2'b00, STAGED = 2'b01, ARMED = 2'b10, BAD = 2'b11} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_min, r_max, r_viol_pc, r_viol_cnt;
    logic        r_cfg_err, r_tamper, r_viol_seen, r_viol_q;

    logic        w_sel, w_wr, w_wr_min, w_wr_max, w_wr_ctrl;
    logic        w_armed, w_arm, w_clr, w_cfg_ok, w_log;
    logic [2:0]  w_off;
    logic [15:0] w_status;

    assign w_sel     = per_en && (per_addr >= BASE_W) && (per_addr <= BASE_W + 14'd5);
    assign w_off     = per_addr[2:0] - BASE_W[2:0];
    assign w_wr      = w_sel && (per_we == 2'b11);
    assign w_wr_min  = w_wr && (w_off == 3'd0);
    assign w_wr_max  = w_wr && (w_off == 3'd1);
    assign w_wr_ctrl = w_wr && (w_off == 3'd2);
    assign w_armed   = (r_state == ARMED);
    assign w_arm     = w_wr_ctrl && per_din[0] && !w_armed;
    assign w_clr     = w_wr_ctrl && per_din[1] && !w_armed;
    assign w_cfg_ok  = (r_min <= r_max) && !r_min[0] && !r_max[0];
    assign w_log     = w_armed && ucca_viol && !r_viol_q;
    assign w_status  = {11'd0, r_viol_seen, r_tamper, r_cfg_err, r_state};

    assign ucc_armed = w_armed;
    assign ucc_min   = w_armed ? r_min : 16'hFFFF;
    assign ucc_max   = w_armed ? r_max : 16'h0000;

    // State register; ARMED is only left through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: staging on bound writes, arming only from STAGED with a valid window
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = (w_wr_min || w_wr_max) ? STAGED : IDLE;
            STAGED:  w_state_nxt = (w_arm && w_cfg_ok) ? ARMED : STAGED;
            ARMED:   w_state_nxt = ARMED;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bound registers, frozen once armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= 16'h0000;
            r_max <= 16'h0000;
        end else begin
            if (w_wr_min && !w_armed) r_min <= per_din;
            if (w_wr_max && !w_armed) r_max <= per_din;
        end
    end

    // Config error and tamper flags; clear is applied before the ARM evaluation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
            r_tamper  <= 1'b0;
        end else begin
            if (w_arm) r_cfg_err <= !((r_state == STAGED) && w_cfg_ok);
            if (w_clr) r_tamper <= 1'b0;
            else if (w_armed && (w_wr_min || w_wr_max || w_wr_ctrl)) r_tamper <= 1'b1;
        end
    end

    // Violation log: rising edges of ucca_viol while armed, saturating count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_viol_q    <= 1'b0;
            r_viol_pc   <= 16'h0000;
            r_viol_cnt  <= 16'h0000;
            r_viol_seen <= 1'b0;
        end else begin
            r_viol_q <= ucca_viol;
            if (w_clr) begin
                r_viol_pc   <= 16'h0000;
                r_viol_cnt  <= 16'h0000;
                r_viol_seen <= 1'b0;
            end else if (w_log) begin
                r_viol_pc   <= pc;
                r_viol_cnt  <= (r_viol_cnt == 16'hFFFF) ? 16'hFFFF : r_viol_cnt + 16'd1;
                r_viol_seen <= 1'b1;
            end
        end
    end

    // Combinational read mux; zero when the window is not selected
    always_comb begin
        per_dout = 16'h0000;
        if (w_sel) begin
            case (w_off)
                3'd0:    per_dout = r_min;
                3'd1:    per_dout = r_max;
                3'd3:    per_dout = w_status;
                3'd4:    per_dout = r_viol_pc;
                3'd5:    per_dout = r_viol_cnt;
                default: per_dout = 16'h0000;
            endcase
        end
    end
endmodule

// File: tb/tb_ucca_config.sv
// tb_ucca_config: directed scenarios plus randomized traffic against a behavioural model
module tb_ucca_config;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic [13:0] per_addr = 14'd0;
    logic [15:0] per_din = 16'd0;
    logic [15:0] pc = 16'd0;
    logic        ucca_viol = 1'b0;
    logic [15:0] per_dout, ucc_min, ucc_max;
    logic        ucc_armed;

    int n_vec = 0;
    int n_bad = 0;

    ucca_config dut (
        .clk(clk), .rst_n(rst_n), .per_en(per_en), .per_we(per_we), .per_addr(per_addr),
        .per_din(per_din), .per_dout(per_dout), .pc(pc), .ucca_viol(ucca_viol),
        .ucc_min(ucc_min), .ucc_max(ucc_max), .ucc_armed(ucc_armed)
    );

    always #5 clk = ~clk;

    // Behavioural model: state 0 idle, 1 staged, 2 armed
    int          m_state;
    logic [15:0] m_min, m_max, m_pc, m_cnt;
    bit          m_err, m_tamp, m_seen, m_prev;

    function automatic int win_off();
        int ba;
        ba = int'(per_addr) * 2;
        return (per_en && ba >= 'h160 && ba < 'h16C) ? (ba - 'h160) / 2 : -1;
    endfunction

    function automatic logic [15:0] exp_dout();
        case (win_off())
            0: return m_min;
            1: return m_max;
            3: return 16'(int'(m_seen) * 16 + int'(m_tamp) * 8 + int'(m_err) * 4 + m_state);
            4: return m_pc;
            5: return m_cnt;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  off;
        bit  wr, rise;
        if (!rst_n) begin
            m_state = 0; m_min = 0; m_max = 0; m_pc = 0; m_cnt = 0;
            m_err = 0; m_tamp = 0; m_seen = 0; m_prev = 0;
        end else begin
            off  = win_off();
            wr   = (off >= 0) && (per_we == 2'b11);
            rise = ucca_viol && !m_prev;
            m_prev = ucca_viol;
            if (m_state == 2) begin
                if (wr && off <= 2) m_tamp = 1;
                if (rise) begin
                    m_pc = pc;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    m_seen = 1;
                end
            end else if (wr) begin
                if (off == 0) m_min = per_din;
                if (off == 1) m_max = per_din;
                if ((off == 0 || off == 1) && m_state == 0) m_state = 1;
                if (off == 2 && per_din[1]) begin
                    m_pc = 0; m_cnt = 0; m_seen = 0; m_tamp = 0;
                end
                if (off == 2 && per_din[0]) begin
                    if (m_state == 1 && m_min <= m_max && !m_min[0] && !m_max[0]) begin
                        m_state = 2; m_err = 0;
                    end else m_err = 1;
                end
            end
        end
    end

    task automatic cyc(input logic en, input logic [1:0] we, input logic [15:0] ba,
                       input logic [15:0] din, input logic v, input logic [15:0] p);
        @(negedge clk);
        per_en = en; per_we = we; per_addr = ba[14:1]; per_din = din; ucca_viol = v; pc = p;
        #1;
    endtask

    task automatic wr(input logic [15:0] ba, input logic [15:0] d);
        cyc(1'b1, 2'b11, ba, d, 1'b0, 16'h0);
    endtask

    task automatic rd(input logic [15:0] ba);
        cyc(1'b1, 2'b00, ba, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; per_en = 1'b0; per_we = 2'b00; ucca_viol = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd(16'(16'h0160 + 2 * i));
            n_vec++; if (per_dout !== 16'h0000) begin n_bad++; $display("FAIL reset_reg%0d: got %h want 0000", i, per_dout); end
        end
        cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0);
        n_vec++; if (ucc_min !== 16'hFFFF) begin n_bad++; $display("FAIL reset_ucc_min: got %h want FFFF", ucc_min); end
        n_vec++; if (ucc_max !== 16'h0000) begin n_bad++; $display("FAIL reset_ucc_max: got %h want 0000", ucc_max); end
        n_vec++; if (ucc_armed !== 1'b0) begin n_bad++; $display("FAIL reset_armed: got %b want 0", ucc_armed); end
    endtask

    task automatic test_arm();
        wr(16'h0160, 16'hE000);
        wr(16'h0162, 16'hE0FE);
        wr(16'h0164, 16'h0001);
        n_vec++; if (ucc_armed !== 1'b0) begin n_bad++; $display("FAIL arm_early: got %b want 0", ucc_armed); end
        rd(16'h0166);
        n_vec++; if (ucc_armed !== 1'b1) begin n_bad++; $display("FAIL arm_armed: got %b want 1", ucc_armed); end
        n_vec++; if (ucc_min !== 16'hE000) begin n_bad++; $display("FAIL arm_min: got %h want E000", ucc_min); end
        n_vec++; if (ucc_max !== 16'hE0FE) begin n_bad++; $display("FAIL arm_max: got %h want E0FE", ucc_max); end
        n_vec++; if (per_dout !== 16'h0002) begin n_bad++; $display("FAIL arm_status: got %h want 0002", per_dout); end
    endtask

    task automatic test_tamper();
        cyc(1'b1, 2'b01, 16'h0160, 16'h0000, 1'b0, 16'h0);
        rd(16'h0166);
        n_vec++; if (per_dout !== 16'h0002) begin n_bad++; $display("FAIL byte_wr_status: got %h want 0002", per_dout); end
        wr(16'h0160, 16'h0000);
        rd(16'h0160);
        n_vec++; if (per_dout !== 16'hE000) begin n_bad++; $display("FAIL tamper_min: got %h want E000", per_dout); end
        n_vec++; if (ucc_min !== 16'hE000) begin n_bad++; $display("FAIL tamper_ucc_min: got %h want E000", ucc_min); end
        rd(16'h0166);
        n_vec++; if (per_dout !== 16'h000A) begin n_bad++; $display("FAIL tamper_status: got %h want 000A", per_dout); end
    endtask

    task automatic test_viol();
        cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 16'hE042);
        cyc(1'b1, 2'b00, 16'h016A, 16'h0, 1'b1, 16'hE042);
        n_vec++; if (per_dout !== 16'h0001) begin n_bad++; $display("FAIL viol_cnt1: got %h want 0001", per_dout); end
        cyc(1'b1, 2'b00, 16'h0168, 16'h0, 1'b1, 16'hE042);
        n_vec++; if (per_dout !== 16'hE042) begin n_bad++; $display("FAIL viol_pc1: got %h want E042", per_dout); end
        cyc(1'b1, 2'b00, 16'h0166, 16'h0, 1'b0, 16'h0);
        n_vec++; if (per_dout !== 16'h001A) begin n_bad++; $display("FAIL viol_status: got %h want 001A", per_dout); end
        cyc(1'b1, 2'b00, 16'h016A, 16'h0, 1'b1, 16'hE050);
        n_vec++; if (per_dout !== 16'h0001) begin n_bad++; $display("FAIL viol_cnt_preupd: got %h want 0001", per_dout); end
        cyc(1'b1, 2'b00, 16'h016A, 16'h0, 1'b0, 16'h0);
        n_vec++; if (per_dout !== 16'h0002) begin n_bad++; $display("FAIL viol_cnt2: got %h want 0002", per_dout); end
        rd(16'h0168);
        n_vec++; if (per_dout !== 16'hE050) begin n_bad++; $display("FAIL viol_pc2: got %h want E050", per_dout); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.r_viol_cnt = 16'hFFFE;
        #1 release dut.r_viol_cnt;
        cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 16'hE060);
        cyc(1'b1, 2'b00, 16'h016A, 16'h0, 1'b0, 16'h0);
        n_vec++; if (per_dout !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach: got %h want FFFF", per_dout); end
        cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 16'hE070);
        cyc(1'b1, 2'b00, 16'h016A, 16'h0, 1'b0, 16'h0);
        n_vec++; if (per_dout !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want FFFF", per_dout); end
        rd(16'h0168);
        n_vec++; if (per_dout !== 16'hE070) begin n_bad++; $display("FAIL sat_pc: got %h want E070", per_dout); end
    endtask

    task automatic test_invalid_arm();
        do_reset();
        wr(16'h0160, 16'hE100);
        wr(16'h0162, 16'hE000);
        wr(16'h0164, 16'h0001);
        rd(16'h0166);
        n_vec++; if (per_dout !== 16'h0005) begin n_bad++; $display("FAIL inv_status: got %h want 0005", per_dout); end
        n_vec++; if (ucc_armed !== 1'b0 || ucc_min !== 16'hFFFF || ucc_max !== 16'h0000) begin
            n_bad++; $display("FAIL inv_outputs: got %b %h %h want 0 FFFF 0000", ucc_armed, ucc_min, ucc_max); end
        wr(16'h0162, 16'hE1FE);
        wr(16'h0164, 16'h0001);
        rd(16'h0166);
        n_vec++; if (per_dout !== 16'h0002) begin n_bad++; $display("FAIL fix_status: got %h want 0002", per_dout); end
        n_vec++; if (ucc_min !== 16'hE100 || ucc_max !== 16'hE1FE) begin
            n_bad++; $display("FAIL fix_bounds: got %h %h want E100 E1FE", ucc_min, ucc_max); end
    endtask

    task automatic test_async_reset();
        cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 16'hE123);
        cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (ucc_armed !== 1'b0 || ucc_min !== 16'hFFFF || ucc_max !== 16'h0000) begin
            n_bad++; $display("FAIL async_outputs: got %b %h %h want 0 FFFF 0000", ucc_armed, ucc_min, ucc_max); end
        for (int i = 0; i < 6; i++) begin
            rd(16'(16'h0160 + 2 * i));
            n_vec++; if (per_dout !== 16'h0000) begin n_bad++; $display("FAIL async_reg%0d: got %h want 0000", i, per_dout); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clr_armed();
        wr(16'h0160, 16'hE000);
        wr(16'h0162, 16'hE0FE);
        wr(16'h0164, 16'h0001);
        cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 16'hE0AA);
        cyc(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0);
        wr(16'h0164, 16'h0002);
        rd(16'h016A);
        n_vec++; if (per_dout !== 16'h0001) begin n_bad++; $display("FAIL clr_armed_cnt: got %h want 0001", per_dout); end
        rd(16'h0166);
        n_vec++; if (per_dout !== 16'h001A) begin n_bad++; $display("FAIL clr_armed_status: got %h want 001A", per_dout); end
    endtask

    task automatic test_random();
        logic [15:0] ba, din, exp_min, exp_max;
        logic [1:0]  we;
        int          k, r;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            k  = $urandom_range(0, 7);
            ba = (k == 0) ? 16'h015E : (k == 7) ? 16'h016C : 16'(16'h0160 + 2 * (k - 1));
            r  = $urandom_range(0, 9);
            we = (r < 6) ? 2'b11 : (r < 9) ? 2'b00 : 2'($urandom_range(1, 2));
            din = (ba == 16'h0164) ? 16'($urandom_range(0, 3)) :
                  ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(2 * $urandom_range(0, 15));
            cyc(1'($urandom_range(0, 9) != 0), we, ba, din, 1'($urandom_range(0, 2) == 0), 16'($urandom));
            if ($urandom_range(0, 79) == 0) begin rst_n = 1'b0; #1; end
            exp_min = (m_state == 2) ? m_min : 16'hFFFF;
            exp_max = (m_state == 2) ? m_max : 16'h0000;
            n_vec++; if (per_dout !== exp_dout()) begin n_bad++; $display("FAIL rnd_dout[%0d]: got %h want %h", n, per_dout, exp_dout()); end
            n_vec++; if (ucc_armed !== (m_state == 2)) begin n_bad++; $display("FAIL rnd_armed[%0d]: got %b want %b", n, ucc_armed, m_state == 2); end
            n_vec++; if (ucc_min !== exp_min) begin n_bad++; $display("FAIL rnd_min[%0d]: got %h want %h", n, ucc_min, exp_min); end
            n_vec++; if (ucc_max !== exp_max) begin n_bad++; $display("FAIL rnd_max[%0d]: got %h want %h", n, ucc_max, exp_max); end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_tamper();
        test_viol();
        test_saturate();
        test_invalid_arm();
        test_async_reset();
        test_clr_armed();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ucca_config.md
# ucca_config

Memory-mapped configuration and status peripheral that programs the untrusted-code-compartment bounds consumed by the UCCA region monitor, and logs the monitor's violations. Trusted boot software writes MIN/MAX, arms the block, and from then on the bounds are frozen until hardware reset. It sits on the openMSP430 peripheral bus. It drives `ucc_min`/`ucc_max` into the monitor and observes the monitor's `reset` output as `ucca_viol`.

## Interface
- `CONF_BASE`, 16'h0160: byte base address of the 6-word register window (0x0160–0x016B); must be word aligned.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; clears all state.
- `per_en`  in  1  peripheral bus access strobe.
- `per_we`  in  2  byte write enables; 2'b11 = word write, 2'b00 = read.
- `per_addr`  in  14  word address (byte address >> 1).
- `per_din`  in  16  write data.
- `per_dout`  out  16  read data; 0 when this block is not selected.
- `pc`  in  16  current program counter, captured on violation.
- `ucca_viol`  in  1  violation/reset request from the region monitor.
- `ucc_min`  out  16  armed lower bound of the compartment.
- `ucc_max`  out  16  armed upper bound of the compartment.
- `ucc_armed`  out  1  1 while in ARMED state.

## Operation
- Select: `per_en` and `per_addr` in [CONF_BASE>>1, (CONF_BASE>>1)+5]. Register offset = `per_addr` − (CONF_BASE>>1).
- Registers by byte address:
  - 0x0160 MIN: read/write.
  - 0x0162 MAX: read/write.
  - 0x0164 CTRL: write-only, reads 0. bit0 = ARM, bit1 = CLR_LOG.
  - 0x0166 STATUS: read-only. [1:0] state, [2] cfg_err, [3] tamper, [4] viol_seen, other bits 0.
  - 0x0168 VIOL_PC: read-only.
  - 0x016A VIOL_CNT: read-only.
- Only word writes (`per_we`=2'b11) take effect. Byte writes to this block are ignored with no flag change. Writes to read-only registers are ignored.
- State machine, encoded in STATUS[1:0]:
  - IDLE (00) is the reset state.
  - IDLE --write MIN or MAX--> STAGED (01).
  - STAGED --ARM with valid config--> ARMED (10), and cfg_err is cleared.
  - Valid config: MIN ≤ MAX (unsigned), MIN[0] = 0, MAX[0] = 0.
  - ARM with invalid config, or ARM in IDLE: state unchanged, cfg_err set to 1.
  - ARMED is left only through `rst_n`. Encoding 11 is unused; if reached, the block returns to IDLE.
- In ARMED, any word write to MIN, MAX or CTRL is ignored and sets sticky tamper = 1.
- Outputs:
  - `ucc_min`/`ucc_max` = registered MIN/MAX while ARMED.
  - Otherwise they are forced to 16'hFFFF/16'h0000, an empty region.
- Violation logging happens only in ARMED. On a rising edge of `ucca_viol` (previous-cycle value 0, current 1):
  - VIOL_PC ← `pc`, overwritten by each new edge.
  - VIOL_CNT ← VIOL_CNT+1, saturating at 16'hFFFF.
  - viol_seen ← 1.
- CLR_LOG (honoured only outside ARMED) zeroes VIOL_PC, VIOL_CNT, viol_seen and tamper. If ARM and CLR_LOG are written together, the clear is applied and then the ARM is evaluated.
- Because logging is gated to ARMED and clearing to non-ARMED, a clear and an increment never occur in the same cycle.

## Timing
- Reset values:
  - `per_dout` = 0, `ucc_min` = 16'hFFFF, `ucc_max` = 0, `ucc_armed` = 0.
  - MIN = MAX = VIOL_PC = VIOL_CNT = 0, state IDLE, all flags 0, edge-detect register 0.
- `rst_n` assertion mid-operation, including while ARMED, takes effect immediately and asynchronously.
- Reads are combinational: `per_dout` is valid in the same cycle as `per_en`. A read in the same cycle as a register update returns the pre-update value.
- Writes take effect on the rising edge that ends the `per_en` cycle.
- After an ARM write, `ucc_armed`, `ucc_min` and `ucc_max` change one cycle later.
- Edge detection: the previous-cycle `ucca_viol` is registered. A level held high counts once. A pulse 1-0-1 counts twice.
- A violation edge in the same cycle as the ARM write is not counted, because the state is not yet ARMED.
- Logged VIOL_PC and VIOL_CNT are readable one cycle after the edge.

## Test plan
- Reset check: release `rst_n`, then read all 6 registers. Expect 0s and STATUS=0x0000; `ucc_min`=FFFF, `ucc_max`=0000, `ucc_armed`=0.
- Normal arm: write MIN=0xE000, MAX=0xE0FE, then CTRL=1.
  - Next cycle: `ucc_armed`=1, `ucc_min`=E000, `ucc_max`=E0FE.
  - STATUS reads 0x0002.
- Invalid arm, then fix:
  - Write MIN=0xE100, MAX=0xE000, CTRL=1. Expect STATUS=0x0005 (STAGED, cfg_err=1) and outputs unchanged.
  - Write MAX=0xE1FE, CTRL=1. Expect STATUS=0x0002.
- Tamper while ARMED: write MIN=0x0000. Expect MIN still reads 0xE000, `ucc_min` still E000, STATUS=0x000A. A byte write to MIN causes no change and no flag.
- Violation logging:
  - With ARMED, hold `ucca_viol` high for 3 cycles at pc=0xE042. Expect VIOL_CNT=1, VIOL_PC=0xE042, STATUS bit4=1.
  - Then pulse it low for 1 cycle and high again at pc=0xE050. Expect VIOL_CNT=2, VIOL_PC=0xE050.
  - Force VIOL_CNT to 0xFFFF and pulse again. Expect it to stay 0xFFFF.
- Reset mid-operation:
  - Assert `rst_n`=0 asynchronously while ARMED. Expect `ucc_armed`=0 immediately and all registers 0.
  - Re-arm, then issue CLR_LOG while ARMED. Expect it to be ignored and tamper=1.
